// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store op codes, FSM states and the alignment rule shared by the store path.
package store_unit_pkg;
  typedef enum logic [1:0] {STOP_SB = 2'b00, STOP_SH = 2'b01, STOP_SW = 2'b10, STOP_RSV = 2'b11} st_op_e;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_FLT} state_e;
  function automatic logic bad_store(st_op_e op, logic [1:0] a);
    return op == STOP_RSV || (op == STOP_SH && a[0]) || (op == STOP_SW && a != 2'b00);
  endfunction
endpackage

// File: rtl/store_unit_if.sv
// store_if: CPU request side and word-addressed data memory side of the store unit.
interface store_if #(parameter int ADDR_W = 32) ();
  logic              start;
  logic [1:0]        st_op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  modport slave (input start, st_op, addr, wdata, mem_rdata, mem_ack,
                 output busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata);
  modport master (output start, st_op, addr, wdata, mem_rdata, mem_ack,
                  input busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/store_unit_merge.sv
// store_merge: splices the byte/halfword of wd_i into the little-endian lanes of old_i.
import store_unit_pkg::*;
module store_merge (
  input  st_op_e      op_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] old_i,
  output logic [31:0] new_o
);
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] L = k[1:0];
    assign new_o[8*k+:8] = op_i == STOP_SW ? wd_i[8*k+:8] :
                           (op_i == STOP_SB && a_i == L) ? wd_i[7:0] :
                           (op_i == STOP_SH && a_i[1] == L[1]) ? wd_i[8*(k%2)+:8] :
                           old_i[8*k+:8];
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: Moore FSM doing single-write word stores and read-modify-write sub-word stores.
import store_unit_pkg::*;
module store_unit #(parameter int ADDR_W = 32) (
  input logic    clk,
  input logic    rst,
  store_if.slave bus
);
  state_e            state_q, state_d;
  st_op_e            op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= STOP_SB;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        op_d    = st_op_e'(bus.st_op);
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        state_d = bad_store(op_d, bus.addr[1:0]) ? S_FLT : op_d == STOP_SW ? S_WR : S_RD;
      end
      S_RD: if (bus.mem_ack) begin
        rdata_d = bus.mem_rdata;
        state_d = S_WR;
      end
      S_WR:    state_d = bus.mem_ack ? S_DONE : S_WR;
      default: state_d = S_IDLE;
    endcase
  end
  // reset clears state_q asynchronously, so the request drops without a clock edge
  assign bus.busy     = state_q != S_IDLE;
  assign bus.done     = state_q == S_DONE || state_q == S_FLT;
  assign bus.fault    = state_q == S_FLT;
  assign bus.mem_req  = state_q == S_RD || state_q == S_WR;
  assign bus.mem_we   = state_q == S_WR;
  assign bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  store_merge u_merge (
    .op_i  (op_q),
    .a_i   (addr_q[1:0]),
    .wd_i  (wdata_q),
    .old_i (rdata_q),
    .new_o (bus.mem_wdata)
  );
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed store vectors against a word memory responder with programmable ack delay.
module tb_store_unit;
  logic clk, rst;
  int checks = 0, errors = 0;
  int ack_dly = 0, cnt = 0, wr_cnt = 0, rd_cnt = 0, req_cyc = 0, done_cnt = 0;
  logic [31:0] last_wa, last_wd, last_ra;
  logic [64:0] prev;
  logic [31:0] mem [logic [31:0]];
  int k, d0;
  logic f;
  store_if #(.ADDR_W(32)) bus ();
  store_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (!bus.mem_req) begin
      cnt = 0;
      bus.mem_ack = 0;
    end else begin
      req_cyc++;
      if (cnt > 0) check("stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, prev);
      prev = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (cnt == ack_dly) begin
        bus.mem_ack = 1;
        cnt = 0;
        if (bus.mem_we) begin
          wr_cnt++;
          last_wa = bus.mem_addr;
          last_wd = bus.mem_wdata;
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rd_cnt++;
          last_ra = bus.mem_addr;
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
        end
      end else begin
        bus.mem_ack = 0;
        cnt++;
      end
    end
  end
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input int dly, input int pulse, output int kk, output logic ff);
    @(posedge clk); #1;
    ack_dly = dly; wr_cnt = 0; rd_cnt = 0; req_cyc = 0;
    bus.start = 1; bus.st_op = op; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.start = 0; bus.st_op = 2'b11; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h5555_5555;
    kk = -1; ff = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      bus.start = n == pulse;
      if (n == pulse) bus.st_op = 2'b10;
      if (bus.done) begin
        kk = n;
        ff = bus.fault;
        break;
      end
    end
    bus.start = 0;
    check("done_seen", kk >= 0, 1);
  endtask
  initial begin
    rst = 1; bus.start = 0; bus.st_op = 0; bus.addr = 0; bus.wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    mem[32'h100] = 32'h1122_3344;
    mem[32'h204] = 32'hAAAA_AAAA;
    #3;
    check("reset_flags", {bus.busy, bus.done, bus.fault, bus.mem_req, bus.mem_we}, 0);
    check("reset_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    run(2'b00, 32'h0000_0102, 32'h0000_00AB, 0, -1, k, f);
    check("sb_lat", k, 2);
    check("sb_fault", f, 0);
    check("sb_rd", {rd_cnt[7:0], last_ra}, {8'd1, 32'h100});
    check("sb_wr", {wr_cnt[7:0], last_wa, last_wd}, {8'd1, 32'h100, 32'h11AB_3344});
    run(2'b01, 32'h0000_0206, 32'h1234_BEEF, 0, -1, k, f);
    check("sh_lat", k, 2);
    check("sh_wr", {last_wa, last_wd}, {32'h204, 32'hBEEF_AAAA});
    run(2'b10, 32'h0000_0300, 32'hDEAD_BEEF, 0, -1, k, f);
    check("sw_lat", k, 1);
    check("sw_req", {rd_cnt[7:0], wr_cnt[7:0], req_cyc[7:0]}, {8'd0, 8'd1, 8'd1});
    check("sw_wr", {last_wa, last_wd}, {32'h300, 32'hDEAD_BEEF});
    run(2'b01, 32'h0000_0101, 32'h0, 0, -1, k, f);
    check("flt_sh", {k[7:0], f, req_cyc[7:0]}, {8'd0, 1'b1, 8'd0});
    run(2'b10, 32'h0000_0302, 32'h0, 0, -1, k, f);
    check("flt_sw", {k[7:0], f, req_cyc[7:0]}, {8'd0, 1'b1, 8'd0});
    run(2'b11, 32'h0000_0400, 32'h0, 0, -1, k, f);
    check("flt_rsv", {k[7:0], f, req_cyc[7:0]}, {8'd0, 1'b1, 8'd0});
    mem[32'h100] = 32'h1122_3344;
    run(2'b00, 32'h0000_0101, 32'h0000_00CD, 3, 2, k, f);
    check("dly_lat", k, 8);
    check("dly_wr", {wr_cnt[7:0], last_wa, last_wd}, {8'd1, 32'h100, 32'h1122_CD44});
    @(negedge clk);
    check("dly_idle", {bus.busy, bus.done}, 0);
    @(posedge clk); #1;
    ack_dly = 1000; bus.start = 1; bus.st_op = 2'b10; bus.addr = 32'h500; bus.wdata = 32'h0BAD_F00D;
    @(posedge clk); #1 bus.start = 0;
    @(negedge clk); @(negedge clk);
    check("rst_pre", {bus.mem_req, bus.mem_we}, 2'b11);
    #2 d0 = done_cnt; rst = 1;
    #1 check("rst_async", {bus.mem_req, bus.busy}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    check("rst_nodone", done_cnt, d0);
    run(2'b10, 32'h0000_0504, 32'hCAFE_F00D, 0, -1, k, f);
    check("post_rst_lat", {k[7:0], f}, {8'd1, 1'b0});
    check("post_rst_wr", {last_wa, last_wd}, {32'h504, 32'hCAFE_F00D});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_unit.md
# store_unit

Store-side counterpart of the immediate/load sign-extension path in the multicycle MIPS datapath: narrows a 32-bit register value to a byte, halfword or word and writes it into the word-addressed data memory. Sub-word stores are done as read-modify-write. Full-word stores are a single write. The control FSM pulses `start` in its MEM state and waits for `done` before advancing. Misaligned and reserved-op stores report `fault` without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  one-cycle request. Accepted only in IDLE.
- `st_op`  in  2  store type: `STOP_SB`=00, `STOP_SH`=01, `STOP_SW`=10; 11 is reserved.
- `addr`  in  ADDR_W  byte address of the store.
- `wdata`  in  32  register value. Only the low byte or halfword is used for SB/SH.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  one-cycle pulse, coincident with `done`, for a rejected store.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read. Meaningful only while `mem_req`=1.
- `mem_addr`  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata`  out  32  merged write word.
- `mem_rdata`  in  32  read word. Valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  completes the current request.

## Operation
- FSM states: IDLE, RD, WR, DONE, FLT. Outputs are decoded from state and registers (Moore).
- Reset values: state=IDLE. `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0. `mem_addr`, `mem_wdata` and all capture registers = 0.
- IDLE + `start`: capture `st_op`, `addr`, `wdata`, then branch:
  - reserved op, SH with addr[0]=1, or SW with addr[1:0]≠0 → FLT.
  - SW → WR, with `mem_wdata` = wdata.
  - SB/SH → RD.
- RD: `mem_req`=1, `mem_we`=0. On `mem_ack`, capture `mem_rdata` into the merge register and go to WR.
- WR: `mem_req`=1, `mem_we`=1, `mem_wdata` = merged word. On `mem_ack`, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- FLT: `done`=1 and `fault`=1 for one cycle, then IDLE. `mem_req` is never asserted for a faulted store.
- Merge (little-endian lanes, lane k = bits 8k+7:8k):
  - SB replaces lane addr[1:0] with wdata[7:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Other lanes keep the read data.
- Boundary rules:
  - `start` while `busy` is ignored.
  - `mem_ack` in IDLE, DONE or FLT is ignored.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until acked.
  - Inputs are not re-sampled after `start`.
  - `rst` mid-operation returns to IDLE immediately: `mem_req` drops asynchronously and no `done` is issued.

## Timing
- `start` is sampled at edge E0.
- SW with zero-wait ack: WR during cycle E0–E1, ack sampled at E1, `done` during E1–E2. That is `done` one cycle after `start` plus N ack wait cycles.
- SB/SH with zero-wait acks: RD for 1 cycle, WR for 1 cycle, then `done`. `done` is asserted 2 cycles after `start` plus wait cycles.
- Fault: `done`/`fault` in the cycle immediately after `start`.
- An ack is accepted in the same cycle the request becomes visible. The minimum request duration is 1 cycle.
- The next `start` can be accepted in the cycle after `done`, when the block is back in IDLE.

## Structure
- `STOP_SB`/`STOP_SH`/`STOP_SW` codes and the state encodings go in the shared `signal_def.v` define header, alongside the `EXTOP_*` codes.
- Sub-module: `store_merge`, a combinational block taking (op, addr[1:0], wdata, old word) and producing the merged word.
- Top level: FSM and capture registers.

## Test plan
- SB, addr=0x00000102, wdata=0x000000AB, memory word at 0x100 = 0x11223344 → read 0x100, then write 0x11AB3344 to 0x100. `done`=1, `fault`=0.
- SH, addr=0x00000206, wdata=0x1234BEEF, memory word at 0x204 = 0xAAAAAAAA → write 0xBEEFAAAA to 0x204.
- SW, addr=0x00000300, wdata=0xDEADBEEF, zero-wait ack → exactly one request (`mem_we`=1, 0xDEADBEEF). No read. `done` one cycle after `start`.
- SH at addr=0x00000101, then SW at 0x00000302, then `st_op`=11 → each gives `done`=`fault`=1 in the next cycle. `mem_req` stays 0 throughout.
- SB with `mem_ack` delayed 3 cycles on both RD and WR, and a second `start` pulsed mid-operation → request signals stay stable. `done` at cycle 8. The second `start` is ignored.
- `rst` asserted while in WR → `mem_req` and `busy` drop without waiting for a clock edge. No `done`. The next SW after reset completes normally.
